// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search used by the UART transmitter arbiter.
package uart_arb_pkg;

  localparam int ARB_STATE_W = 2;
  localparam int RR_MAX_REQ  = 8;

  typedef enum logic [ARB_STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } arb_state_e;

  // First set bit of req strictly after ptr, wrapping modulo n; returns ptr when req is empty.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [2:0]            ptr,
                                         input int                    n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= RR_MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i <= n) && req[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin requester picker: combinational search plus the last-winner pointer.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   pick_o
);

  logic [IDX_W-1:0]      ptr_q;
  logic [RR_MAX_REQ-1:0] req_ext;
  logic [2:0]            pick_full;

  assign req_ext   = RR_MAX_REQ'(req_i);
  assign pick_full = rr_pick(req_ext, 3'(ptr_q), NUM_REQ);
  assign pick_o    = IDX_W'(pick_full);
  assign any_o     = |req_i;

  // Pointer starts at the last index so requester 0 wins the first search.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else if (advance_i) begin
      ptr_q <= pick_o;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to add lockIN, which keeps multi-byte messages contiguous.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOAD_TIMEOUT = 65535,
  parameter int CNT_W        = 17
) (
  input  logic                 clockIN,
  input  logic                 nResetIN,
  input  logic [NUM_REQ-1:0]   reqIN,
  input  logic [8*NUM_REQ-1:0] dataIN,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]   lockIN,
`endif
  output logic [NUM_REQ-1:0]   ackOUT,
  output logic [NUM_REQ-1:0]   grantOUT,
  output logic [7:0]           txDataOUT,
  output logic                 txLoadOUT,
  input  logic                 txReadyIN,
  input  logic                 txIdleIN,
  output logic                 busyOUT,
  output logic                 errOUT,
  output arb_state_e           dbgStateOUT
);

  // Handshake: txLoadOUT is held with stable txDataOUT until synced ready falls
  // (accept); the requester then sees a one-cycle ackOUT and must hold reqIN until it.
  localparam int               IDX_W        = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  logic [1:0] rdy_sync_q, idle_sync_q;
  logic       rdy_s, idle_s;

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      rdy_sync_q  <= 2'b11;
      idle_sync_q <= 2'b11;
    end else begin
      rdy_sync_q  <= {rdy_sync_q[0], txReadyIN};
      idle_sync_q <= {idle_sync_q[0], txIdleIN};
    end
  end

  assign rdy_s  = rdy_sync_q[1];
  assign idle_s = idle_sync_q[1];

  logic [7:0] data_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = dataIN[8*g +: 8];
  end

  logic             any_req;
  logic [IDX_W-1:0] pick;
  logic             ptr_adv;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .clk_i     (clockIN),
    .rst_ni    (nResetIN),
    .req_i     (reqIN),
    .advance_i (ptr_adv),
    .any_o     (any_req),
    .pick_o    (pick)
  );

  arb_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]       data_q, data_d;
  logic             load_q, load_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] win_q, win_d;

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      load_q  <= load_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    load_d  = load_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ptr_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req && rdy_s) begin
          win_d   = pick;
          grant_d = NUM_REQ'(1) << pick;
          data_d  = data_arr[pick];
          load_d  = 1'b1;
          cnt_d   = '0;
          ptr_adv = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!rdy_s) begin
          load_d  = 1'b0;
          ack_d   = grant_q;
          state_d = BUSY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Pointer already moved to this requester, so a stuck one cannot starve others.
          load_d  = 1'b0;
          err_d   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BUSY: begin
        if (rdy_s) begin
`ifdef UART_ARB_LOCK_EN
          if (lockIN[win_q] && reqIN[win_q]) begin
            data_d  = data_arr[win_q];
            load_d  = 1'b1;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
`else
          grant_d = '0;
          state_d = IDLE;
`endif
        end
      end
      default: begin
        grant_d = '0;
        load_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ackOUT      = ack_q;
  assign grantOUT    = grant_q;
  assign txDataOUT   = data_q;
  assign txLoadOUT   = load_q;
  assign errOUT      = err_q;
  assign busyOUT     = (state_q != IDLE) | ~idle_s;
  assign dbgStateOUT = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a simple transmitter model and ack scoreboard.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N          = 4;
  localparam int TO         = 20;
  localparam int ACCEPT_DLY = 3;
  localparam int BUSY_LEN   = 8;
  localparam int W          = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   reqIN;
  logic [8*N-1:0] dataIN;
  logic [N-1:0]   ackOUT, grantOUT;
  logic [7:0]     txDataOUT;
  logic           txLoadOUT, busyOUT, errOUT;
  logic           tx_ready, tx_idle;
  arb_state_e     dbg_state;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;
  int           n_chk = 0;
  int           n_err = 0;
  logic         tx_accept_en;
  logic [7:0]   cap_byte;
  logic         drop_en;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .LOAD_TIMEOUT (TO),
    .CNT_W        (17)
  ) dut (
    .clockIN     (clk),
    .nResetIN    (rst_n),
    .reqIN       (reqIN),
    .dataIN      (dataIN),
`ifdef UART_ARB_LOCK_EN
    .lockIN      (lock),
`endif
    .ackOUT      (ackOUT),
    .grantOUT    (grantOUT),
    .txDataOUT   (txDataOUT),
    .txLoadOUT   (txLoadOUT),
    .txReadyIN   (tx_ready),
    .txIdleIN    (tx_idle),
    .busyOUT     (busyOUT),
    .errOUT      (errOUT),
    .dbgStateOUT (dbg_state)
  );

  // Transmitter model: accepts a load after ACCEPT_DLY cycles, then is busy BUSY_LEN cycles.
  initial begin : tx_model
    int dly;
    int cnt;
    bit phase;
    tx_ready = 1'b1;
    tx_idle  = 1'b1;
    cap_byte = '0;
    dly = 0;
    cnt = 0;
    phase = 1'b0;
    forever begin
      @(negedge clk);
      if (!phase) begin
        if (txLoadOUT && tx_accept_en) begin
          dly++;
          if (dly == ACCEPT_DLY) begin
            tx_ready = 1'b0;
            tx_idle  = 1'b0;
            cap_byte = txDataOUT;
            phase    = 1'b1;
            cnt      = 0;
          end
        end else begin
          dly = 0;
        end
      end else begin
        cnt++;
        if (cnt == BUSY_LEN) begin
          tx_ready = 1'b1;
          tx_idle  = 1'b1;
          phase    = 1'b0;
          dly      = 0;
        end
      end
    end
  end

  // Scoreboard: every ack must match the next expected {ack one-hot, transmitted byte}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ackOUT !== '0) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ack: got ack=%b byte=%h, required no ack", ackOUT, cap_byte);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({ackOUT, cap_byte} !== sb_exp) begin
          n_err++;
          $display("FAIL sb_ack_byte: got ack=%b byte=%h, required ack=%b byte=%h",
                   ackOUT, cap_byte, sb_exp[11:8], sb_exp[7:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    if (drop_en) reqIN = reqIN & ~ackOUT;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reqIN = '0;
    drop_en = 1'b0;
    tx_accept_en = 1'b1;
    exp_q.delete();
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reqIN = '0;
    dataIN = '0;
    drop_en = 1'b0;
    tx_accept_en = 1'b1;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(negedge clk);
    n_chk++; if (grantOUT !== '0) begin n_err++; $display("FAIL reset_grant: got %b, required 0000", grantOUT); end
    n_chk++; if (ackOUT !== '0) begin n_err++; $display("FAIL reset_ack: got %b, required 0000", ackOUT); end
    n_chk++; if (txLoadOUT !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b, required 0", txLoadOUT); end
    n_chk++; if (txDataOUT !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, required 00", txDataOUT); end
    n_chk++; if (errOUT !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", errOUT); end
    n_chk++; if (busyOUT !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busyOUT); end
    n_chk++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int lc;
    do_reset();
    drop_en = 1'b1;
    dataIN[7:0] = 8'hA5;
    exp_q.push_back({4'b0001, 8'hA5});
    reqIN = 4'b0001;
    tick();
    n_chk++; if (txLoadOUT !== 1'b1) begin n_err++; $display("FAIL single_load_rise: got %b, required 1", txLoadOUT); end
    n_chk++; if (txDataOUT !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h, required a5", txDataOUT); end
    n_chk++; if (grantOUT !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b, required 0001", grantOUT); end
    lc = 0;
    for (int c = 0; c < 50 && txLoadOUT; c++) begin
      lc++;
      tick();
    end
    n_chk++; if (lc != ACCEPT_DLY + 2) begin n_err++; $display("FAIL single_load_len: got %0d, required %0d", lc, ACCEPT_DLY + 2); end
    n_chk++; if (ackOUT !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b, required 0001", ackOUT); end
    tick();
    n_chk++; if (ackOUT !== 4'b0000) begin n_err++; $display("FAIL single_ack_width: got %b, required 0000", ackOUT); end
    n_chk++; if (grantOUT !== 4'b0001) begin n_err++; $display("FAIL single_grant_busy: got %b, required 0001", grantOUT); end
    for (int c = 0; c < 40 && grantOUT !== '0; c++) tick();
    n_chk++; if (grantOUT !== '0) begin n_err++; $display("FAIL single_grant_clear: got %b, required 0000", grantOUT); end
    n_chk++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_first: got ready=%b, required 1", tx_ready); end
    n_chk++; if (busyOUT !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b, required 0", busyOUT); end
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_sb_empty: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    do_reset();
    dataIN = {8'h44, 8'h33, 8'h22, 8'h11};
    exp_q.push_back({4'b0001, 8'h11});
    exp_q.push_back({4'b0010, 8'h22});
    exp_q.push_back({4'b0100, 8'h33});
    exp_q.push_back({4'b1000, 8'h44});
    exp_q.push_back({4'b0001, 8'h11});
    reqIN = 4'b1111;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) tick();
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_sb_empty: got %0d pending, required 0", exp_q.size()); end
    reqIN = '0;
    for (int c = 0; c < 60 && (grantOUT !== '0 || busyOUT !== 1'b0); c++) tick();
    n_chk++; if (grantOUT !== '0 || busyOUT !== 1'b0) begin n_err++; $display("FAIL rr_idle: got grant=%b busy=%b, required 0000/0", grantOUT, busyOUT); end
  endtask

  task automatic test_timeout();
    int lc;
    do_reset();
    tx_accept_en = 1'b0;
    dataIN = {8'h00, 8'h00, 8'hD2, 8'hE1};
    reqIN = 4'b0011;
    tick();
    n_chk++; if (grantOUT !== 4'b0001) begin n_err++; $display("FAIL to_grant0: got %b, required 0001", grantOUT); end
    lc = 0;
    for (int c = 0; c < 100 && txLoadOUT; c++) begin
      lc++;
      tick();
    end
    n_chk++; if (lc != TO) begin n_err++; $display("FAIL to_load_len: got %0d, required %0d", lc, TO); end
    n_chk++; if (errOUT !== 1'b1) begin n_err++; $display("FAIL to_err_pulse: got %b, required 1", errOUT); end
    n_chk++; if (grantOUT !== '0) begin n_err++; $display("FAIL to_grant_clear: got %b, required 0000", grantOUT); end
    reqIN[0] = 1'b0;
    exp_q.push_back({4'b0010, 8'hD2});
    tx_accept_en = 1'b1;
    drop_en = 1'b1;
    tick();
    n_chk++; if (errOUT !== 1'b0) begin n_err++; $display("FAIL to_err_width: got %b, required 0", errOUT); end
    n_chk++; if (grantOUT !== 4'b0010) begin n_err++; $display("FAIL to_next_grant: got %b, required 0010", grantOUT); end
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL to_sb_empty: got %0d pending, required 0", exp_q.size()); end
    for (int c = 0; c < 60 && (grantOUT !== '0 || busyOUT !== 1'b0); c++) tick();
    n_chk++; if (grantOUT !== '0 || busyOUT !== 1'b0) begin n_err++; $display("FAIL to_idle: got grant=%b busy=%b, required 0000/0", grantOUT, busyOUT); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    drop_en = 1'b1;
    dataIN = {8'h00, 8'h00, 8'h00, 8'h3C};
    exp_q.push_back({4'b0001, 8'h3C});
    reqIN = 4'b0001;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    tick();
    n_chk++; if (dbg_state !== BUSY) begin n_err++; $display("FAIL rb_in_busy: got state %0d, required %0d", dbg_state, BUSY); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (grantOUT !== '0) begin n_err++; $display("FAIL rb_grant: got %b, required 0000", grantOUT); end
    n_chk++; if (txLoadOUT !== 1'b0 || ackOUT !== '0 || errOUT !== 1'b0) begin
      n_err++; $display("FAIL rb_ctrl: got load=%b ack=%b err=%b, required 0/0000/0", txLoadOUT, ackOUT, errOUT);
    end
    n_chk++; if (txDataOUT !== 8'h00) begin n_err++; $display("FAIL rb_data: got %h, required 00", txDataOUT); end
    n_chk++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rb_state: got %0d, required %0d", dbg_state, IDLE); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40 && tx_ready !== 1'b1; c++) tick();
    repeat (4) tick();
    dataIN = {8'h00, 8'h00, 8'h72, 8'h71};
    exp_q.push_back({4'b0001, 8'h71});
    exp_q.push_back({4'b0010, 8'h72});
    reqIN = 4'b0011;
    tick();
    n_chk++; if (grantOUT !== 4'b0001) begin n_err++; $display("FAIL rb_ptr_reset: got %b, required 0001", grantOUT); end
    for (int c = 0; c < 150 && exp_q.size() != 0; c++) tick();
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rb_sb_empty: got %0d pending, required 0", exp_q.size()); end
    for (int c = 0; c < 60 && (grantOUT !== '0 || busyOUT !== 1'b0); c++) tick();
    n_chk++; if (grantOUT !== '0 || busyOUT !== 1'b0) begin n_err++; $display("FAIL rb_idle: got grant=%b busy=%b, required 0000/0", grantOUT, busyOUT); end
  endtask

  task automatic test_withdraw();
    do_reset();
    dataIN = {8'h00, 8'h5C, 8'h00, 8'h00};
    exp_q.push_back({4'b0100, 8'h5C});
    reqIN = 4'b0100;
    tick();
    n_chk++; if (txLoadOUT !== 1'b1 || grantOUT !== 4'b0100) begin
      n_err++; $display("FAIL wd_load: got load=%b grant=%b, required 1/0100", txLoadOUT, grantOUT);
    end
    reqIN = '0;
    dataIN = '0;
    tick();
    n_chk++; if (txLoadOUT !== 1'b1 || txDataOUT !== 8'h5C) begin
      n_err++; $display("FAIL wd_hold: got load=%b data=%h, required 1/5c", txLoadOUT, txDataOUT);
    end
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wd_sb_empty: got %0d pending, required 0", exp_q.size()); end
    for (int c = 0; c < 60 && (grantOUT !== '0 || busyOUT !== 1'b0); c++) tick();
    n_chk++; if (grantOUT !== '0 || busyOUT !== 1'b0) begin n_err++; $display("FAIL wd_idle: got grant=%b busy=%b, required 0000/0", grantOUT, busyOUT); end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    int bad;
    do_reset();
    dataIN = {8'h00, 8'hC2, 8'hB1, 8'h00};
    lock = 4'b0010;
    repeat (3) exp_q.push_back({4'b0010, 8'hB1});
    reqIN = 4'b0110;
    bad = 0;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      tick();
      if (grantOUT !== 4'b0010) bad++;
    end
    n_chk++; if (bad != 0) begin n_err++; $display("FAIL lock_grant_held: got %0d cycles off 0010, required 0", bad); end
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lock_sb_empty: got %0d pending, required 0", exp_q.size()); end
    lock = '0;
    reqIN = 4'b0100;
    exp_q.push_back({4'b0100, 8'hC2});
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lock_next_sb: got %0d pending, required 0", exp_q.size()); end
    reqIN = '0;
    for (int c = 0; c < 60 && (grantOUT !== '0 || busyOUT !== 1'b0); c++) tick();
    n_chk++; if (grantOUT !== '0 || busyOUT !== 1'b0) begin n_err++; $display("FAIL lock_idle: got grant=%b busy=%b, required 0000/0", grantOUT, busyOUT); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_busy();
    test_withdraw();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
